baud_autodetect: RTL
====================

# baud_autodetect

Autobaud controller for the UART oversampling tick generator. It measures the bit period of a received 0x55 sync character on the serial line and computes the clock divisor the programmable baud-tick generator must load to produce 16 ticks per bit. It sits between the RX pin and the divisor input of the tick generator. The host arms it once per detection.

## Interface

Parameters:
- CLK_FREQ, 100E6: system clock frequency in Hz.
- DIV_NBITS, 16: width of the divisor output.
- DEFAULT_DIV, CLK_FREQ/(16*9600) = 651: divisor value driven from reset until the first successful lock.
- Derived localparam CNT_NBITS = DIV_NBITS+7: width of the measurement counter.

Ports:
- i_clk, input, 1: clock.
- i_rst, input, 1: reset; synchronous, active-high, sampled on i_clk.
- i_rx, input, 1: asynchronous serial line; idle level is high.
- i_start, input, 1: one-cycle arm request.
- o_divisor, output, DIV_NBITS: tick period in clocks, for the tick generator.
- o_done, output, 1: one-cycle pulse when a new divisor is latched.
- o_error, output, 1: one-cycle pulse when a measurement is aborted.
- o_locked, output, 1: level; set after the first success, cleared only by reset.
- o_busy, output, 1: high in every state except IDLE.

## Operation

- i_rx passes through a 2-flop synchronizer whose flops reset to 1. Edge detection operates on the synchronized value.
- The 0x55 frame, LSB first, is a 0/1 alternation. Falling edges occur at bit times 0, 2, 4, 6 and 8. The span from the 1st to the 5th falling edge is exactly 8 bit periods, or 128 tick periods.
- State IDLE: i_start moves to ARM. i_start is ignored in every other state.
- State ARM: the block waits until the synchronized rx is high, then moves to WAIT_START. This rejects arming in the middle of a frame.
- State WAIT_START: a falling edge moves to MEASURE. On that transition, cnt is set to 0 and fall_cnt is set to 0.
- State MEASURE:
  - cnt increments every cycle.
  - Each falling edge increments fall_cnt.
  - On the 4th falling edge counted in MEASURE, the block computes div = (cnt+1+64)>>7, truncated to DIV_NBITS.
  - If div is not 0, the block latches o_divisor, pulses o_done, sets o_locked and returns to IDLE.
  - If div is 0 (span < 64 clocks, a glitch), the block pulses o_error and o_divisor is unchanged.
  - Rising edges are ignored.
- Timeout: if cnt reaches all-ones in MEASURE, the block pulses o_error, leaves o_divisor unchanged and returns to IDLE.
- A falling edge coinciding with the timeout cycle counts as a timeout.
- Reset mid-operation: the state goes to IDLE and the synchronizer goes to 1. o_divisor = DEFAULT_DIV, and o_done, o_error, o_locked and o_busy are all 0.

## Timing

- Reset values: o_divisor = DEFAULT_DIV; all other outputs 0.
- i_rx to edge-detect latency: 2 cycles for the synchronizer plus 1 cycle for edge registration. The latency is equal for both edges, so the measured span is unaffected.
- The measured span in clocks equals cnt+1 at the 5th falling edge. For an ideal frame this equals 8 × bit_clks.
- o_done and o_error are registered. They assert in the cycle after the decisive edge or timeout, for exactly 1 cycle. The state is IDLE in that same cycle.
- o_divisor changes only in the cycle o_done asserts.
- o_busy rises the cycle after i_start is accepted.

## Configuration

- Macro: BAUD_AUTODETECT_CHECK_EN.
- Defined:
  - MEASURE additionally times each of the 4 falling-to-falling intervals.
  - The first interval is stored as the reference.
  - Each later interval must lie within ±(ref>>3) of the reference.
  - On a violation, the block pulses o_error at the offending edge, leaves o_divisor unchanged and returns to IDLE.
- Undefined: no interval checking. Only the total span and the timeout are evaluated.

## Test plan

- Reset: after reset, o_divisor = 651, and o_locked, o_busy, o_done and o_error are all 0.
- 9600-baud lock: drive 0x55 at 10416 clocks/bit, then pulse i_start. Required response: a single o_done pulse, o_divisor = 651, o_locked = 1.
- 115200-baud lock: drive 0x55 at 868 clocks/bit. Required response: o_divisor = 54. A repeat at 9600 baud must return 651.
- Timeout: send a start edge, then hold i_rx low. Required response: o_error after 2^23 − 1 cycles, o_divisor unchanged, o_busy = 0.
- Glitch and arm rules:
  - A 20-cycle low pulse followed by an idle line is not a frame; the pulse alone must not produce o_done.
  - Five falling edges within 60 clocks must give o_error.
  - An i_start pulse while o_busy = 1 must be ignored.
  - Arming while rx is low must wait for high before detecting the start edge.
- Check macro: drive a 0x55 frame at 868 clocks/bit whose 3rd interval is stretched to 2000 clocks.
  - With BAUD_AUTODETECT_CHECK_EN: o_error.
  - Without it: o_done with the divisor computed from the total span.
- Reset mid-MEASURE: assert i_rst halfway through a frame. Required response: all outputs return to reset values the next cycle. A fresh frame after reset must then lock correctly.

Source files
------------

// File: rtl/baud_autodetect.sv
// Autobaud controller: times a received 0x55 sync character and produces the
// 16x-oversampling divisor. Optional interval checking via BAUD_AUTODETECT_CHECK_EN.
module baud_autodetect #(
   parameter int CLK_FREQ    = 100_000_000,
   parameter int DIV_NBITS   = 16,
   parameter int DEFAULT_DIV = CLK_FREQ / (16 * 9600)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_rx,
   input  logic                 i_start,
   output logic [DIV_NBITS-1:0] o_divisor,
   output logic                 o_done,
   output logic                 o_error,
   output logic                 o_locked,
   output logic                 o_busy
);

   localparam int CNT_NBITS = DIV_NBITS + 7;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      WAIT_START,
      MEASURE
   } state_t;

   state_t                 state, state_n;
   logic                   rx_meta, rx_sync, rx_d;
   logic [CNT_NBITS-1:0]   cnt;
   logic [1:0]             fall_cnt;
   logic                   fall;
   logic                   timeout;
   logic [CNT_NBITS-1:0]   span;
   logic [CNT_NBITS:0]     span_rnd;
   logic [DIV_NBITS-1:0]   div_calc;
   logic                   ival_bad;
   logic                   done_n, error_n, load_div;

   assign fall     = rx_d & ~rx_sync;
   assign timeout  = &cnt;
   assign span     = cnt + CNT_NBITS'(1);
   // Rounded divide by 128 ticks; the extra top bit keeps the +64 from wrapping.
   assign span_rnd = {1'b0, span} + (CNT_NBITS + 1)'(64);
   assign div_calc = DIV_NBITS'(span_rnd >> 7);
   assign o_busy   = (state != IDLE);

`ifdef BAUD_AUTODETECT_CHECK_EN
   logic [CNT_NBITS-1:0] prev_edge;
   logic [CNT_NBITS-1:0] ref_ival;
   logic [CNT_NBITS-1:0] ival;
   logic [CNT_NBITS-1:0] ival_diff;

   assign ival      = span - prev_edge;
   assign ival_diff = (ival >= ref_ival) ? (ival - ref_ival) : (ref_ival - ival);
   // The first interval becomes the reference, so only later edges are judged.
   assign ival_bad  = (fall_cnt != 2'd0) && (ival_diff > (ref_ival >> 3));
`else
   assign ival_bad  = 1'b0;
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_n  = state;
      done_n   = 1'b0;
      error_n  = 1'b0;
      load_div = 1'b0;
      case (state)
         IDLE:       if (i_start) state_n = ARM;
         ARM:        if (rx_sync) state_n = WAIT_START;
         WAIT_START: if (fall)    state_n = MEASURE;
         MEASURE: begin
            if (timeout) begin
               error_n = 1'b1;
               state_n = IDLE;
            end else if (fall) begin
               if (ival_bad) begin
                  error_n = 1'b1;
                  state_n = IDLE;
               end else if (fall_cnt == 2'd3) begin
                  state_n = IDLE;
                  if (div_calc != '0) begin
                     done_n   = 1'b1;
                     load_div = 1'b1;
                  end else begin
                     error_n  = 1'b1;
                  end
               end
            end
         end
         default:    state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (i_rst) begin
         state     <= IDLE;
         rx_meta   <= 1'b1;
         rx_sync   <= 1'b1;
         rx_d      <= 1'b1;
         cnt       <= '0;
         fall_cnt  <= '0;
         o_divisor <= DIV_NBITS'(DEFAULT_DIV);
         o_done    <= 1'b0;
         o_error   <= 1'b0;
         o_locked  <= 1'b0;
`ifdef BAUD_AUTODETECT_CHECK_EN
         prev_edge <= '0;
         ref_ival  <= '0;
`endif
      end else begin
         rx_meta <= i_rx;
         rx_sync <= rx_meta;
         rx_d    <= rx_sync;
         state   <= state_n;
         o_done  <= done_n;
         o_error <= error_n;
         if (load_div) begin
            o_divisor <= div_calc;
            o_locked  <= 1'b1;
         end
         if (state == WAIT_START) begin
            cnt      <= '0;
            fall_cnt <= '0;
`ifdef BAUD_AUTODETECT_CHECK_EN
            prev_edge <= '0;
            ref_ival  <= '0;
`endif
         end else if (state == MEASURE) begin
            cnt <= cnt + CNT_NBITS'(1);
            if (fall) begin
               fall_cnt <= fall_cnt + 2'd1;
`ifdef BAUD_AUTODETECT_CHECK_EN
               prev_edge <= span;
               if (fall_cnt == 2'd0) ref_ival <= ival;
`endif
            end
         end
      end
   end

endmodule
